// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one byte as start bit, DATA_BITS data
// bits (LSB first) and one stop bit. Bit timing comes from an internal baud
// divider. The data bit on the line is selected by an external 4-bit
// bit-select counter, which this block steps with cnt_en and clears with
// cnt_rst.
//
// Host handshake: start is sampled only while busy=0 (IDLE). A start seen
// in IDLE latches data_in and begins a frame on the next cycle. A start
// while busy=1 is dropped; it is not queued and data_q keeps the current
// byte. done pulses for one cycle in the first IDLE cycle after the stop
// bit, and a start in that same cycle is accepted.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [3:0] bit_cnt,
  output logic       cnt_en,
  output logic       cnt_rst,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          baud_last;

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  // Next-state, baud divider and byte latch. Any bit_cnt at or above the
  // last data bit ends the DATA phase, so a bad count cannot hang a frame.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (start) begin
          data_d  = data_in;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt >= LAST_BIT) begin
            state_d = S_STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = S_IDLE;
          done_d     = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // Line and counter-control outputs decoded from registered state.
  always_comb begin
    tx      = 1'b1;
    busy    = 1'b1;
    cnt_rst = 1'b1;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: tx   = 1'b0;
      S_DATA: begin
        // Only the low three bits can address the byte; counts past the
        // last bit never reach a second bit period.
        tx      = data_q[bit_cnt[2:0]];
        cnt_rst = 1'b0;
        cnt_en  = baud_last && (bit_cnt < LAST_BIT);
      end
      S_STOP:  tx = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at CLKS_PER_BIT=4, DATA_BITS=8, with a
// behavioural bit-select counter driven by cnt_en/cnt_rst.
module tb_uart_tx_ctrl;

  localparam int CPB   = 4;
  localparam int NB    = 8;
  localparam int FRAME = (NB + 2) * CPB;   // 40 cycles from start bit to end of stop bit

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STOP = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] bit_cnt;
  logic [3:0] cnt_q;
  logic       force_bad;
  logic       cnt_en, cnt_rst, tx, busy, done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .bit_cnt   (bit_cnt),
    .cnt_en    (cnt_en),
    .cnt_rst   (cnt_rst),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // External bit-select counter
  always_ff @(posedge clk) begin
    if (cnt_rst)     cnt_q <= 4'd0;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end

  assign bit_cnt = force_bad ? 4'd15 : cnt_q;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One full frame of byte b, checked cycle by cycle through the done cycle.
  // prestarted: edge 0 already happened (back-to-back). ign_cycle: cycle in
  // which a stray start with 0x3C is pulsed. chain: start next_b in done cycle.
  task automatic run_frame(input logic [7:0] b, input bit prestarted, input int ign_cycle,
                           input bit chain, input logic [7:0] next_b);
    logic [9:0] bits;
    logic [0:0] exp_bit;
    int en_count;
    en_count = 0;
    bits = {1'b1, b, 1'b0};
    exp_q.delete();
    for (int c = 1; c <= FRAME; c++) exp_q.push_back(bits[(c - 1) / CPB]);
    exp_q.push_back(1'b1);
    if (!prestarted) begin
      data_in = b;
      start   = 1'b1;
      step();
    end
    start = 1'b0;
    for (int c = 1; c <= FRAME + 1; c++) begin
      exp_bit = exp_q.pop_front();
      chk("tx", 32'(tx), 32'(exp_bit));
      chk("busy", 32'(busy), 32'(c <= FRAME));
      chk("done", 32'(done), 32'(c == FRAME + 1));
      chk("cnt_en", 32'(cnt_en), 32'(c >= 2 * CPB && c <= NB * CPB && (c % CPB) == 0));
      chk("cnt_rst", 32'(cnt_rst), 32'(!(c > CPB && c <= (NB + 1) * CPB)));
      if (c > CPB && c <= (NB + 1) * CPB)
        chk("bit_cnt", 32'(bit_cnt), 32'((c - CPB - 1) / CPB));
      if (cnt_en) en_count++;
      start = 1'b0;
      if (c == ign_cycle) begin
        start   = 1'b1;
        data_in = 8'h3C;
      end
      if (c == FRAME + 1 && chain) begin
        start   = 1'b1;
        data_in = next_b;
      end
      step();
    end
    if (!chain) start = 1'b0;
    chk("cnt_en_total", 32'(en_count), 32'(NB - 1));
    if (!chain) begin
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_tx", 32'(tx), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    data_in   = 8'hFF;
    force_bad = 1'b0;

    // Reset held 3 cycles with start high
    repeat (3) begin
      step();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt_rst", 32'(cnt_rst), 32'd1);
      chk("rst_cnt_en", 32'(cnt_en), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_tx", 32'(tx), 32'd1);
    end

    // Single frame 0xA5
    run_frame(8'hA5, 1'b0, 0, 1'b0, 8'h00);

    // Back-to-back 0x00 then 0xFF, second start in the done cycle
    run_frame(8'h00, 1'b0, 0, 1'b1, 8'hFF);
    run_frame(8'hFF, 1'b1, 0, 1'b0, 8'h00);

    // Stray start with 0x3C in cycle 10 of a 0xA5 frame
    run_frame(8'hA5, 1'b0, 10, 1'b0, 8'h00);

    // Reset in cycle 20 of a 0x5A frame
    data_in = 8'h5A;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      chk("mid_busy", 32'(busy), 32'd1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt_rst", 32'(cnt_rst), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2 * CPB) begin
      step();
      chk("mid_rst_no_done", 32'(done), 32'd0);
      chk("mid_rst_idle", 32'(busy), 32'd0);
    end
    run_frame(8'h96, 1'b0, 0, 1'b0, 8'h00);

    // Reset and start together: reset wins
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 8'h81;
    step();
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_state", 32'(state_dbg), 32'(ST_IDLE));
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("rst_start_after", 32'(busy), 32'd0);
    chk("rst_start_tx", 32'(tx), 32'd1);

    // Bit counter forced to 15 during data bit 2 (cycles 13..16)
    data_in = 8'hA5;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 13) begin force_bad = 1'b1; #1; end
      if (c == 17) begin force_bad = 1'b0; #1; end
      if (c >= 13 && c <= 16) chk("bad_cnt_en", 32'(cnt_en), 32'd0);
      if (c >= 17 && c <= 20) begin
        chk("bad_state", 32'(state_dbg), 32'(ST_STOP));
        chk("bad_tx", 32'(tx), 32'd1);
        chk("bad_busy", 32'(busy), 32'd1);
      end
      chk("bad_done", 32'(done), 32'(c == 21));
      step();
    end
    chk("bad_post_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that frames one byte as start bit, DATA_BITS data bits (LSB first) and one stop bit on the serial line. It drives the existing 4-bit bit-select counter through `cnt_en` and `cnt_rst`, and consumes its count on `bit_cnt` to choose the data bit on the line. It sits between the host byte interface and the TX pin. Bit timing comes from an internal baud divider.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal values are ≥ 2.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 1..8.
- `clk`  in  1  system clock. All logic runs on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start`  in  1  request to send `data_in`. Sampled only in IDLE.
- `data_in`  in  8  byte to send. Latched when `start` is accepted.
- `bit_cnt`  in  4  current count from the bit-select counter.
- `cnt_en`  out  1  one-cycle increment strobe to the bit-select counter.
- `cnt_rst`  out  1  synchronous clear to the bit-select counter.
- `tx`  out  1  serial line. Idles high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, STOP. The state register and `baud_cnt` are both cleared by `rst`.
- `baud_cnt` is an internal counter of width clog2(CLKS_PER_BIT).
  - In START, DATA and STOP it counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1 it wraps to 0, and the state advances or the bit advances.
  - In IDLE it is held at 0.
- IDLE
  - `tx`=1, `busy`=0, `cnt_rst`=1.
  - If `start`=1, latch `data_in` into `data_q` and go to START.
- START
  - `tx`=0, `busy`=1, `cnt_rst`=1, so the counter is held at 0.
  - After CLKS_PER_BIT cycles, go to DATA.
- DATA
  - `tx`=`data_q[bit_cnt]`, `busy`=1, `cnt_rst`=0.
  - At the end of each bit period:
    - If `bit_cnt` < DATA_BITS-1, assert `cnt_en` for that one cycle and stay in DATA.
    - Otherwise go to STOP without asserting `cnt_en`.
  - A `bit_cnt` ≥ DATA_BITS-1 is treated as the last bit. Out-of-range counts therefore terminate the frame rather than hang.
- STOP
  - `tx`=1, `busy`=1, `cnt_rst`=1.
  - After CLKS_PER_BIT cycles, go to IDLE and pulse `done`.
- Output sources:
  - `tx`, `busy`, `cnt_en` and `cnt_rst` are decoded from registered state, `baud_cnt`, `data_q` and `bit_cnt`.
  - `done` is a register.
- `start` while `busy`=1 is ignored. It is not queued, and `data_q` is unchanged.

## Timing
- Reset values: state IDLE, `tx`=1, `busy`=0, `done`=0, `cnt_en`=0, `cnt_rst`=1, `baud_cnt`=0, `data_q`=0.
- Cycle numbering: the edge that accepts `start` is edge 0.
  - Cycles 1..CLKS_PER_BIT: START, with `tx` low.
  - Data bit k occupies cycles (k+1)·CLKS_PER_BIT+1 .. (k+2)·CLKS_PER_BIT.
  - Stop bit follows the last data bit for CLKS_PER_BIT cycles.
- `done` is high in the first IDLE cycle, i.e. cycle (DATA_BITS+2)·CLKS_PER_BIT+1, for exactly one cycle.
- Back-to-back frames: `start`=1 in the `done` cycle is accepted. The next start bit begins the following cycle, with no idle gap beyond that single cycle.
- The counter increments on the edge where `cnt_en`=1. The new `bit_cnt` is therefore valid on the first cycle of the next bit.
- `rst` mid-frame: the next cycle is IDLE, with `tx`=1, `busy`=0, `cnt_rst`=1 and no `done` pulse. The partial frame is abandoned.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → `tx`=1, `busy`=0, `done`=0, `cnt_rst`=1 throughout. No frame starts until the first `start` after `rst` falls.
- Single frame: CLKS_PER_BIT=4, `data_in`=0xA5.
  - Required `tx`, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `done` pulses in cycle 41.
  - `cnt_en` pulses exactly 7 times.
- Back-to-back: assert `start` with 0x00 and 0xFF, the second `start` in the `done` cycle.
  - Exactly one high cycle separates the stop bit from the second start bit.
  - The second frame's data bits are all 1.
- Ignore while busy: pulse `start` with 0x3C in cycle 10 of a 0xA5 frame → the frame still carries 0xA5, and only one `done` is produced.
- Reset mid-frame: assert `rst` in cycle 20 → next cycle `tx`=1, `busy`=0, `cnt_rst`=1, no `done`. A new `start` then produces a full, correct frame.
- Bad counter: the bench forces `bit_cnt`=15 during DATA → the FSM enters STOP at the end of that bit period and `done` still pulses.
